// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin common-data-bus arbiter with one result buffer per functional unit
//   clk, rst        clock, synchronous active-high reset
//   flush           mispredict flush, drops buffered and in-flight results
//   fu_valid/tag/data, fu_ready   per-unit result handshake (slice i = unit i)
//   cdb_valid/tag/data            registered broadcast channels (slice c = channel c)
//   rob_set_valid                 one-hot OR of broadcast tags, aligned with cdb_valid
module cdb_arbiter #(
    parameter int NUM_FU    = 5,
    parameter int NUM_CDB   = 2,
    parameter int TAG_W     = 3,
    parameter int ROB_DEPTH = 8,
    parameter int DATA_W    = 32
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [NUM_FU-1:0]           fu_valid,
    input  logic [NUM_FU*TAG_W-1:0]     fu_tag,
    input  logic [NUM_FU*DATA_W-1:0]    fu_data,
    output logic [NUM_FU-1:0]           fu_ready,
    output logic [NUM_CDB-1:0]          cdb_valid,
    output logic [NUM_CDB*TAG_W-1:0]    cdb_tag,
    output logic [NUM_CDB*DATA_W-1:0]   cdb_data,
    output logic [ROB_DEPTH-1:0]        rob_set_valid
);
    localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0]   buf_valid;
    logic [TAG_W-1:0]    buf_tag  [NUM_FU];
    logic [DATA_W-1:0]   buf_data [NUM_FU];
    logic [PW-1:0]       rr_ptr, last, nxt_ptr;
    logic [NUM_FU-1:0]   rot, gr_rot, grant;
    logic [2*NUM_FU-1:0] gr_dbl;
    logic [NUM_CDB-1:0]  ch_vld;
    logic [PW-1:0]       ch_idx [NUM_CDB];
    logic [ROB_DEPTH-1:0] set_nxt;
    int                  n;

    // Scan in a rotated view so position k is unit (rr_ptr+k) mod NUM_FU,
    // then rotate the grants back into unit order.
    always_comb begin
        rot = NUM_FU'({buf_valid, buf_valid} >> rr_ptr);
        gr_rot = '0;
        ch_vld = '0;
        last = '0;
        n = 0;
        for (int c = 0; c < NUM_CDB; c++) ch_idx[c] = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (rot[k] && n < NUM_CDB) begin
                gr_rot[k] = 1'b1;
                last = PW'((int'(rr_ptr) + k) % NUM_FU);
                for (int c = 0; c < NUM_CDB; c++) begin
                    if (n == c) begin
                        ch_vld[c] = 1'b1;
                        ch_idx[c] = last;
                    end
                end
                n = n + 1;
            end
        end
        gr_dbl = {gr_rot, gr_rot} << rr_ptr;
        grant = gr_dbl[2*NUM_FU-1:NUM_FU];
        set_nxt = '0;
        for (int c = 0; c < NUM_CDB; c++)
            if (ch_vld[c]) set_nxt[buf_tag[ch_idx[c]]] = 1'b1;
    end

    assign nxt_ptr  = (last == PW'(NUM_FU - 1)) ? '0 : last + 1'b1;
    // A granted entry drains this cycle, so it can be refilled at the same edge.
    assign fu_ready = ~buf_valid | grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid     <= '0;
            rr_ptr        <= '0;
            cdb_valid     <= '0;
            cdb_tag       <= '0;
            cdb_data      <= '0;
            rob_set_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (fu_valid[i] && fu_ready[i] && !flush) begin
                    buf_valid[i] <= 1'b1;
                    buf_tag[i]   <= fu_tag[i*TAG_W +: TAG_W];
                    buf_data[i]  <= fu_data[i*DATA_W +: DATA_W];
                end else if (grant[i] || flush) begin
                    buf_valid[i] <= 1'b0;
                end
            end
            for (int c = 0; c < NUM_CDB; c++) begin
                if (ch_vld[c]) begin
                    cdb_tag[c*TAG_W +: TAG_W]    <= buf_tag[ch_idx[c]];
                    cdb_data[c*DATA_W +: DATA_W] <= buf_data[ch_idx[c]];
                end
            end
            cdb_valid     <= flush ? '0 : ch_vld;
            rob_set_valid <= flush ? '0 : set_nxt;
            if (!flush && |grant) rr_ptr <= nxt_ptr;
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed vector bench for cdb_arbiter (NUM_CDB=2 main instance, NUM_CDB=1 fairness instance)
module tb_cdb_arbiter;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush = 1'b0;
    logic [4:0]   fu_valid = '0;
    logic [14:0]  fu_tag = '0;
    logic [159:0] fu_data = '0;
    logic [4:0]   fu_ready;
    logic [1:0]   cdb_valid;
    logic [5:0]   cdb_tag;
    logic [63:0]  cdb_data;
    logic [7:0]   rob_set_valid;

    logic [4:0]   fu_valid1 = '0;
    logic [14:0]  fu_tag1 = '0;
    logic [159:0] fu_data1 = '0;
    logic [4:0]   fu_ready1;
    logic [0:0]   cdb_valid1;
    logic [2:0]   cdb_tag1;
    logic [31:0]  cdb_data1;
    logic [7:0]   rob_set_valid1;

    int total = 0;
    int pass = 0;

    always #5 clk = ~clk;

    cdb_arbiter dut (
        .clk(clk), .rst(rst), .flush(flush),
        .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_data(fu_data), .fu_ready(fu_ready),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .rob_set_valid(rob_set_valid)
    );

    cdb_arbiter #(.NUM_CDB(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .fu_valid(fu_valid1), .fu_tag(fu_tag1), .fu_data(fu_data1), .fu_ready(fu_ready1),
        .cdb_valid(cdb_valid1), .cdb_tag(cdb_tag1), .cdb_data(cdb_data1), .rob_set_valid(rob_set_valid1)
    );

    // Two live buffers with the same ROB tag is an illegal stimulus.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 5; i++)
                for (int j = i + 1; j < 5; j++)
                    if (dut.buf_valid[i] && dut.buf_valid[j] && dut.buf_tag[i] == dut.buf_tag[j])
                        $error("duplicate tag %0d in buffers %0d and %0d", dut.buf_tag[i], i, j);
        end
    end

    typedef struct {
        logic        rst;
        logic        flush;
        logic [4:0]  fv;
        logic [14:0] tags;
        logic [4:0]  rdy;
        logic [1:0]  cv;
        logic [5:0]  ct;
        logic [7:0]  rsv;
        logic        zero;
    } vec_t;

    vec_t tv [23];

    function automatic logic [14:0] tg(input logic [2:0] t4, t3, t2, t1, t0);
        return {t4, t3, t2, t1, t0};
    endfunction

    function automatic logic [31:0] dof(input logic [2:0] t);
        return {8'hA5, 21'h0, t};
    endfunction

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a === e) pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, a, e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0]  mt;
        logic [63:0] md;
        logic [63:0] ed;
        tv[0]  = '{1'b1, 1'b0, 5'b00000, tg(0,0,0,0,0), 5'b11111, 2'b00, 6'o00, 8'h00, 1'b1};
        tv[1]  = '{1'b0, 1'b0, 5'b11011, tg(4,3,0,2,1), 5'b00111, 2'b00, 6'o00, 8'h00, 1'b0};
        tv[2]  = '{1'b0, 1'b0, 5'b00000, tg(0,0,0,0,0), 5'b11111, 2'b11, 6'o21, 8'h06, 1'b0};
        tv[3]  = '{1'b0, 1'b0, 5'b00000, tg(0,0,0,0,0), 5'b11111, 2'b11, 6'o43, 8'h18, 1'b0};
        tv[4]  = '{1'b0, 1'b0, 5'b00000, tg(0,0,0,0,0), 5'b11111, 2'b00, 6'o00, 8'h00, 1'b0};
        tv[5]  = '{1'b0, 1'b0, 5'b00010, tg(0,0,0,0,0), 5'b11111, 2'b00, 6'o00, 8'h00, 1'b0};
        for (int t = 1; t < 8; t++)
            tv[5+t] = '{1'b0, 1'b0, 5'b00010, tg(0,0,0,3'(t),0), 5'b11111, 2'b01, 6'(t-1), 8'(1 << (t-1)), 1'b0};
        tv[13] = '{1'b0, 1'b0, 5'b00000, tg(0,0,0,0,0), 5'b11111, 2'b01, 6'o07, 8'h80, 1'b0};
        tv[14] = '{1'b0, 1'b0, 5'b00000, tg(0,0,0,0,0), 5'b11111, 2'b00, 6'o00, 8'h00, 1'b0};
        tv[15] = '{1'b0, 1'b0, 5'b00111, tg(0,0,3,2,1), 5'b11101, 2'b00, 6'o00, 8'h00, 1'b0};
        tv[16] = '{1'b0, 1'b1, 5'b01000, tg(0,5,0,0,0), 5'b11111, 2'b00, 6'o00, 8'h00, 1'b0};
        tv[17] = '{1'b0, 1'b0, 5'b00000, tg(0,0,0,0,0), 5'b11111, 2'b00, 6'o00, 8'h00, 1'b0};
        tv[18] = '{1'b0, 1'b0, 5'b00000, tg(0,0,0,0,0), 5'b11111, 2'b00, 6'o00, 8'h00, 1'b0};
        tv[19] = '{1'b0, 1'b0, 5'b00011, tg(0,0,0,7,6), 5'b11111, 2'b00, 6'o00, 8'h00, 1'b0};
        tv[20] = '{1'b0, 1'b0, 5'b11100, tg(3,2,1,0,0), 5'b01111, 2'b11, 6'o76, 8'hC0, 1'b0};
        tv[21] = '{1'b1, 1'b0, 5'b00000, tg(0,0,0,0,0), 5'b11111, 2'b00, 6'o00, 8'h00, 1'b1};
        tv[22] = '{1'b0, 1'b0, 5'b00000, tg(0,0,0,0,0), 5'b11111, 2'b00, 6'o00, 8'h00, 1'b0};

        #2;
        for (int k = 0; k < 23; k++) begin
            rst = tv[k].rst;
            flush = tv[k].flush;
            fu_valid = tv[k].fv;
            fu_tag = tv[k].tags;
            for (int i = 0; i < 5; i++) fu_data[i*32 +: 32] = dof(tv[k].tags[i*3 +: 3]);
            tick();
            mt = {{3{tv[k].cv[1]}}, {3{tv[k].cv[0]}}};
            md = {{32{tv[k].cv[1]}}, {32{tv[k].cv[0]}}};
            ed = {dof(tv[k].ct[5:3]), dof(tv[k].ct[2:0])};
            chk($sformatf("r%0d fu_ready", k), 64'(fu_ready), 64'(tv[k].rdy));
            chk($sformatf("r%0d cdb_valid", k), 64'(cdb_valid), 64'(tv[k].cv));
            chk($sformatf("r%0d cdb_tag", k), 64'(cdb_tag & mt), 64'(tv[k].ct & mt));
            chk($sformatf("r%0d cdb_data", k), cdb_data & md, ed & md);
            chk($sformatf("r%0d rob_set_valid", k), 64'(rob_set_valid), 64'(tv[k].rsv));
            if (tv[k].zero) begin
                chk($sformatf("r%0d reset cdb_tag", k), 64'(cdb_tag), 64'h0);
                chk($sformatf("r%0d reset cdb_data", k), cdb_data, 64'h0);
            end
        end
        rst = 1'b0;
        flush = 1'b0;
        fu_valid = '0;

        // Fairness with one channel: units 0 and 4 request every cycle.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fu_valid1 = 5'b10001;
        fu_tag1 = tg(6,0,0,0,1);
        for (int i = 0; i < 5; i++) fu_data1[i*32 +: 32] = dof(fu_tag1[i*3 +: 3]);
        tick();
        chk("fair fill cdb_valid", 64'(cdb_valid1), 64'h0);
        chk("fair fill fu_ready", 64'(fu_ready1), 64'b01111);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("fair c%0d cdb_valid", k), 64'(cdb_valid1), 64'h1);
            chk($sformatf("fair c%0d cdb_tag", k), 64'(cdb_tag1), (k % 2) ? 64'd6 : 64'd1);
            chk($sformatf("fair c%0d cdb_data", k), 64'(cdb_data1), 64'(dof((k % 2) ? 3'd6 : 3'd1)));
        end
        fu_valid1 = '0;

        // Single result: handshake, one cycle in the buffer, one cycle on the bus.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fu_valid = 5'b00100;
        fu_tag = tg(0,0,5,0,0);
        fu_data = '0;
        fu_data[64 +: 32] = 32'hDEADBEEF;
        tick();
        fu_valid = '0;
        chk("single buffered cdb_valid", 64'(cdb_valid), 64'h0);
        tick();
        chk("single cdb_valid", 64'(cdb_valid), 64'h1);
        chk("single cdb_tag", 64'(cdb_tag[2:0]), 64'd5);
        chk("single cdb_data", 64'(cdb_data[31:0]), 64'hDEADBEEF);
        chk("single rob_set_valid", 64'(rob_set_valid), 64'h20);
        tick();
        chk("single after cdb_valid", 64'(cdb_valid), 64'h0);
        chk("single after rob_set_valid", 64'(rob_set_valid), 64'h0);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Parametrised common-data-bus arbiter between the functional units (ALUs, branch compare, load unit) and the ROB and reservation stations.
- Replaces the fixed one-slot-per-tag broadcast with a per-unit one-entry result buffer and NUM_CDB registered broadcast channels.
- Channels are granted round-robin, so more units may finish in a cycle than there are bus channels without losing results.
- Also drives the ROB's set-valid vector and supports flush on branch mispredict.

Parameters:
- NUM_FU, 5, number of producing functional units.
- NUM_CDB, 2, number of broadcast channels per cycle (1..NUM_FU).
- TAG_W, 3, ROB tag width.
- ROB_DEPTH, 8, ROB entries (2**TAG_W).
- DATA_W, 32, result width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  mispredict flush; discards all buffered and in-flight results.
- fu_valid  in  NUM_FU  unit i presents a result.
- fu_tag  in  NUM_FU*TAG_W  ROB tag of unit i's result (slice i).
- fu_data  in  NUM_FU*DATA_W  result data of unit i (slice i).
- fu_ready  out  NUM_FU  buffer i can accept this cycle.
- cdb_valid  out  NUM_CDB  channel c broadcasts this cycle.
- cdb_tag  out  NUM_CDB*TAG_W  tag on channel c.
- cdb_data  out  NUM_CDB*DATA_W  data on channel c.
- rob_set_valid  out  ROB_DEPTH  one-hot OR of broadcast tags, aligned with cdb_valid.

Behaviour:
- Reset: one clock, synchronous, active-high. On rst all buffers invalid; rr_ptr=0; cdb_valid=0, cdb_tag=0, cdb_data=0, rob_set_valid=0. fu_ready is all 1s in the cycle after reset.
- Per-unit buffer: buf_valid[i], buf_tag[i], buf_data[i].
- fu_ready[i] = ~buf_valid[i] | grant[i].
  - grant depends only on registered state, so there is no combinational path from fu_valid to fu_ready.
  - A handshake (fu_valid & fu_ready) writes the buffer at the edge.
  - If the same entry is granted in that cycle, the write replaces it, so each unit sustains one result per cycle.
- Arbitration is combinational on buf_valid and rr_ptr:
  - Scan units in order rr_ptr, rr_ptr+1, ... (mod NUM_FU).
  - The first valid unit goes to channel 0, the second to channel 1, up to NUM_CDB grants.
  - Ungranted entries hold their contents.
- Broadcast: at the edge, each granted entry loads into channel c's output registers and cdb_valid[c]=1. Unused channels get cdb_valid=0; their tag and data are don't-care but held.
- Latency: handshake in cycle N -> buffer valid in N+1 -> on the bus in N+2 at the earliest.
- rob_set_valid[t]=1 in the same cycle as any cdb_valid[c] with cdb_tag[c]==t.
- Round-robin pointer:
  - After any grant, rr_ptr = (index of last granted unit + 1) mod NUM_FU.
  - With no grant, rr_ptr is unchanged.
  - Wraps from NUM_FU-1 to 0.
- Flush, effective at the edge: clears all buf_valid, cdb_valid and rob_set_valid. A handshake in the flush cycle is dropped (flush wins). rr_ptr is kept.
- rst has priority over flush and over every other event. Reset mid-stream discards all buffered results.
- Two valid buffers holding the same tag is illegal: a bench assertion flags it and the RTL does not check for it.
- No other wrap-around or overflow cases exist: at most one result is held per unit.
- NUM_CDB >= NUM_FU degenerates to grant-all-valid every cycle.

Test Plan:
- Single result: rst then fu_valid[2]=1, tag=5, data=0xDEADBEEF for one cycle -> two cycles later cdb_valid=2'b01, cdb_tag[0]=5, cdb_data[0]=0xDEADBEEF, rob_set_valid=8'h20, all for exactly one cycle.
- Over-subscription: units 0,1,3,4 each present one result with tags 1,2,3,4 in the same cycle, NUM_CDB=2 -> first broadcast is tags 1,2 on ch0,ch1; next cycle tags 3,4. fu_ready[3], fu_ready[4] stay 0 until units 3 and 4 are granted.
- Fairness: units 0 and 4 both assert fu_valid continuously with NUM_CDB=1 -> grants alternate 0,4,0,4; neither unit starves for more than one cycle.
- Full throughput: unit 1 streams tags 0..7 back-to-back with no competition -> fu_ready[1] stays 1 and eight consecutive cdb_valid cycles carry tags 0..7 in order.
- Flush: three buffered results plus one handshake in the flush cycle -> next cycle cdb_valid=0 and rob_set_valid=0; the dropped result never appears on the bus.
- Reset mid-stream: rst asserted while two channels are broadcasting -> next cycle all outputs are 0 and fu_ready is all 1s.
